// File: rtl/sic_muldiv_lock_arbiter_if.sv
// ---------------------------------------------------------------------------
// sic_muldiv_lock_arbiter_if
// Bundle between the SIC array and the mul/div lock arbiter.
//   req            : per-SIC lock request (level)
//   req_issue_id   : issue id per SIC, slot i at [i*ID_WIDTH +: ID_WIDTH]
//   release_lock   : per-SIC one-cycle release pulse
//   head_issue_id  : issue id of the oldest uncommitted instruction
//   flush          : pipeline flush, drops the lock
//   grant          : one-hot-or-zero grant back to the SICs
//   owner_valid    : lock currently held
//   owner_idx      : holder index (0 when no holder)
//   err_stray_rel  : sticky stray-release flag
// master = SIC side (drives requests), slave = arbiter.
// ---------------------------------------------------------------------------
interface sic_muldiv_lock_arbiter_if #(
  parameter int NUM_SICS = 4,
  parameter int ID_WIDTH = 8
);
  localparam int IDX_W = $clog2(NUM_SICS);

  logic [NUM_SICS-1:0]          req;
  logic [NUM_SICS*ID_WIDTH-1:0] req_issue_id;
  logic [NUM_SICS-1:0]          release_lock;
  logic [ID_WIDTH-1:0]          head_issue_id;
  logic                         flush;
  logic [NUM_SICS-1:0]          grant;
  logic                         owner_valid;
  logic [IDX_W-1:0]             owner_idx;
  logic                         err_stray_rel;

  modport master (
    output req, req_issue_id, release_lock, head_issue_id, flush,
    input  grant, owner_valid, owner_idx, err_stray_rel
  );

  modport slave (
    input  req, req_issue_id, release_lock, head_issue_id, flush,
    output grant, owner_valid, owner_idx, err_stray_rel
  );
endinterface

// File: rtl/sic_muldiv_lock_arbiter.sv
// ---------------------------------------------------------------------------
// sic_muldiv_lock_arbiter
// Owns the lock on the shared mul/div unit. Grants the oldest requester
// (age measured from the commit head, modulo 2**ID_WIDTH), holds it until
// the owner releases, then hands off to the next oldest with no bubble.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   bus    : sic_muldiv_lock_arbiter_if.slave (requests in, grant/status out)
// ---------------------------------------------------------------------------
module sic_muldiv_lock_arbiter #(
  parameter int NUM_SICS = 4,
  parameter int ID_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  sic_muldiv_lock_arbiter_if.slave      bus
);
  localparam int IDX_W = $clog2(NUM_SICS);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_owner_idx;
  logic             r_err;

  state_t           w_nxt_state;
  logic [IDX_W-1:0] w_nxt_idx;
  logic             w_nxt_err;
  logic [NUM_SICS-1:0] w_owner_oh;
  logic [NUM_SICS-1:0] w_stray;
  logic [IDX_W:0]      w_win_all;
  logic [IDX_W:0]      w_win_rem;

  // Oldest requester in mask: {found, idx}. Strict '<' keeps the lowest
  // index on equal ages since slots are scanned upward.
  function automatic logic [IDX_W:0] f_oldest(
    input logic [NUM_SICS-1:0]          mask,
    input logic [NUM_SICS*ID_WIDTH-1:0] ids,
    input logic [ID_WIDTH-1:0]          head
  );
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [ID_WIDTH-1:0] best;
    logic [ID_WIDTH-1:0] age;
    found = 1'b0;
    idx   = '0;
    best  = '0;
    for (int i = 0; i < NUM_SICS; i++) begin
      if (mask[i]) begin
        age = ids[i*ID_WIDTH +: ID_WIDTH] - head;
        if (!found || age < best) begin
          found = 1'b1;
          idx   = IDX_W'(i);
          best  = age;
        end
      end
    end
    return {found, idx};
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner_idx <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_owner_idx <= w_nxt_idx;
      r_err       <= w_nxt_err;
    end
  end

  // Next-state logic
  always_comb begin
    w_owner_oh  = (r_state == ST_LOCKED) ? (NUM_SICS'(1) << r_owner_idx) : '0;
    // Any release bit not belonging to the current owner is stray.
    w_stray     = bus.release_lock & ~w_owner_oh;
    w_win_all   = f_oldest(bus.req, bus.req_issue_id, bus.head_issue_id);
    // On handoff the releasing owner is excluded even if its req is still up.
    w_win_rem   = f_oldest(bus.req & ~w_owner_oh, bus.req_issue_id, bus.head_issue_id);
    w_nxt_state = r_state;
    w_nxt_idx   = r_owner_idx;
    w_nxt_err   = r_err | (|w_stray);

    if (bus.flush) begin
      w_nxt_state = ST_IDLE;
      w_nxt_idx   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_win_all[IDX_W]) begin
            w_nxt_state = ST_LOCKED;
            w_nxt_idx   = w_win_all[IDX_W-1:0];
          end
        end
        ST_LOCKED: begin
          if (|(bus.release_lock & w_owner_oh)) begin
            if (w_win_rem[IDX_W]) begin
              w_nxt_idx = w_win_rem[IDX_W-1:0];
            end else begin
              w_nxt_state = ST_IDLE;
              w_nxt_idx   = '0;
            end
          end
        end
        default: begin
          w_nxt_state = ST_IDLE;
          w_nxt_idx   = '0;
        end
      endcase
    end
  end

  // Outputs: grant follows registered ownership gated by the owner's live req.
  always_comb begin
    bus.owner_valid   = (r_state == ST_LOCKED);
    bus.owner_idx     = r_owner_idx;
    bus.err_stray_rel = r_err;
    bus.grant         = '0;
    if (r_state == ST_LOCKED) begin
      bus.grant = (NUM_SICS'(1) << r_owner_idx) & bus.req;
    end
  end

endmodule

// File: tb/tb_sic_muldiv_lock_arbiter.sv
module tb_sic_muldiv_lock_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  sic_muldiv_lock_arbiter_if #(.NUM_SICS(4), .ID_WIDTH(8)) bus();

  sic_muldiv_lock_arbiter #(.NUM_SICS(4), .ID_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input int slot, input logic [7:0] id);
    bus.req_issue_id[slot*8 +: 8] = id;
  endtask

  task automatic chk_st(input string tag, input logic [3:0] g, input logic ov,
                        input logic [1:0] idx);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".ov"},    32'(bus.owner_valid), 32'(ov));
    chk({tag, ".idx"},   32'(bus.owner_idx), 32'(idx));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.req = '0;
    bus.req_issue_id = '0;
    bus.release_lock = '0;
    bus.head_issue_id = '0;
    bus.flush = 1'b0;
    step();
    step();
    chk_st("rst", 4'b0000, 1'b0, 2'd0);
    chk("rst.err", 32'(bus.err_stray_rel), 32'd0);
    rst_n = 1'b1;

    // 1. single requester
    set_id(2, 8'h05); bus.head_issue_id = 8'h00; bus.req = 4'b0100;
    chk("t1.pre", 32'(bus.grant), 32'd0);
    step();
    chk_st("t1.lock", 4'b0100, 1'b1, 2'd2);
    bus.release_lock = 4'b0100;
    step();
    bus.release_lock = '0; bus.req = '0;
    chk_st("t1.idle", 4'b0000, 1'b0, 2'd0);

    // 2. age order and zero-bubble handoff
    set_id(0, 8'h10); set_id(3, 8'h0C); bus.head_issue_id = 8'h08; bus.req = 4'b1001;
    step();
    chk_st("t2.own3", 4'b1000, 1'b1, 2'd3);
    bus.release_lock = 4'b1000;
    step();
    bus.release_lock = '0; bus.req = 4'b0001;
    chk_st("t2.own0", 4'b0001, 1'b1, 2'd0);
    bus.release_lock = 4'b0001; bus.req = '0;
    step();
    bus.release_lock = '0;
    chk("t2.idle", 32'(bus.owner_valid), 32'd0);

    // 3. wrap-around age
    bus.head_issue_id = 8'hFE; set_id(1, 8'h01); set_id(2, 8'hFF); bus.req = 4'b0110;
    step();
    chk_st("t3.wrap", 4'b0100, 1'b1, 2'd2);
    bus.release_lock = 4'b0100; bus.req = '0;
    step();
    bus.release_lock = '0;
    chk("t3.idle", 32'(bus.owner_valid), 32'd0);

    // tie: equal ages -> lowest index
    bus.head_issue_id = 8'h00; set_id(1, 8'h30); set_id(3, 8'h30); bus.req = 4'b1010;
    step();
    chk_st("tie", 4'b0010, 1'b1, 2'd1);
    bus.release_lock = 4'b0010; bus.req = '0;
    step();
    bus.release_lock = '0;
    chk("tie.idle", 32'(bus.owner_valid), 32'd0);

    // 4. no preemption, owner drops req
    set_id(1, 8'h20); set_id(0, 8'h00); bus.req = 4'b0010;
    step();
    chk_st("t4.own1", 4'b0010, 1'b1, 2'd1);
    bus.req = 4'b0011;
    step();
    chk_st("t4.nopre", 4'b0010, 1'b1, 2'd1);
    bus.req = 4'b0001;
    step();
    chk_st("t4.drop", 4'b0000, 1'b1, 2'd1);
    bus.release_lock = 4'b0010;
    step();
    bus.release_lock = '0;
    chk_st("t4.hand", 4'b0001, 1'b1, 2'd0);
    chk("t4.err", 32'(bus.err_stray_rel), 32'd0);

    // 5. stray release
    bus.release_lock = 4'b1000;
    step();
    bus.release_lock = '0;
    chk_st("t5.keep", 4'b0001, 1'b1, 2'd0);
    chk("t5.err", 32'(bus.err_stray_rel), 32'd1);
    step();
    chk("t5.sticky", 32'(bus.err_stray_rel), 32'd1);

    // 6. flush with requests pending, then relock, then reset mid-lock
    bus.req = 4'b0011; bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk_st("t6.flush", 4'b0000, 1'b0, 2'd0);
    chk("t6.err", 32'(bus.err_stray_rel), 32'd1);
    step();
    chk_st("t6.relock", 4'b0001, 1'b1, 2'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; bus.req = '0;
    chk_st("t6.rst", 4'b0000, 1'b0, 2'd0);
    chk("t6.rsterr", 32'(bus.err_stray_rel), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
